// File: rtl/gesture_uart_rx.sv
// gesture_uart_rx: 8N1 UART receiver feeding a SYNC/G/~G packet parser.
// Ports: clk, reset (async low), rx -> gesture, gesture_valid, frame_err, pkt_err.
module gesture_uart_rx #(
  parameter int         CLK_HZ       = 50_000_000,
  parameter int         BAUD         = 115200,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] gesture,
  output logic       gesture_valid,
  output logic       frame_err,
  output logic       pkt_err
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int TLIM = TIMEOUT_BITS * CPB;
  localparam int TW   = $clog2(TLIM + 1);

  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [TW-1:0] TLIM_M1 = TW'(TLIM - 1);

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_WAIT
  } bstate_t;

  typedef enum logic [1:0] {
    P_SYNC,
    P_DATA,
    P_CHK
  } pstate_t;

  logic          rx_m;
  logic          rx_s;
  bstate_t       bstate;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          bdone;
  logic [7:0]    bbyte;
  pstate_t       pstate;
  logic [7:0]    g_tmp;
  logic [TW-1:0] tcnt;
  logic          fe_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // A frame error about to be flagged wins over a same-cycle
  // timeout so the pulse outputs stay mutually exclusive.
  assign fe_nxt = (bstate == B_STOP) &&
                  (cnt == CPB_M1) && !rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bstate    <= B_IDLE;
      cnt       <= '0;
      bidx      <= '0;
      shreg     <= '0;
      bdone     <= 1'b0;
      bbyte     <= '0;
      frame_err <= 1'b0;
    end else begin
      bdone     <= 1'b0;
      frame_err <= 1'b0;
      unique case (bstate)
        B_IDLE: begin
          cnt <= '0;
          if (!rx_s) bstate <= B_START;
        end
        B_START: begin
          if (cnt == HALF_M1) begin
            cnt    <= '0;
            bidx   <= '0;
            bstate <= rx_s ? B_IDLE : B_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        B_DATA: begin
          if (cnt == CPB_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            bidx  <= bidx + 3'd1;
            if (bidx == 3'd7) bstate <= B_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        B_STOP: begin
          if (cnt == CPB_M1) begin
            cnt <= '0;
            if (rx_s) begin
              bdone  <= 1'b1;
              bbyte  <= shreg;
              bstate <= B_IDLE;
            end else begin
              frame_err <= 1'b1;
              bstate    <= B_WAIT;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        B_WAIT: begin
          if (rx_s) bstate <= B_IDLE;
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pstate        <= P_SYNC;
      g_tmp         <= '0;
      tcnt          <= '0;
      gesture       <= '0;
      gesture_valid <= 1'b0;
      pkt_err       <= 1'b0;
    end else begin
      gesture_valid <= 1'b0;
      pkt_err       <= 1'b0;
      if (frame_err) begin
        pstate <= P_SYNC;
        tcnt   <= '0;
      end else if (bdone) begin
        tcnt <= '0;
        unique case (pstate)
          P_SYNC: begin
            if (bbyte == SYNC_BYTE) pstate <= P_DATA;
          end
          P_DATA: begin
            g_tmp  <= bbyte;
            pstate <= P_CHK;
          end
          P_CHK: begin
            if (bbyte == ~g_tmp) begin
              gesture       <= g_tmp;
              gesture_valid <= 1'b1;
              pstate        <= P_SYNC;
            end else begin
              pkt_err <= 1'b1;
              // a SYNC in the checksum slot may start a new packet
              pstate  <= (bbyte == SYNC_BYTE) ? P_DATA : P_SYNC;
            end
          end
          default: pstate <= P_SYNC;
        endcase
      end else if (pstate != P_SYNC) begin
        if (tcnt >= TLIM_M1) begin
          tcnt <= '0;
          if (!fe_nxt) begin
            pkt_err <= 1'b1;
            pstate  <= P_SYNC;
          end
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gesture_uart_rx.sv
// tb_gesture_uart_rx: directed vectors for the UART gesture receiver.
// 10 clk per bit; packets from a table plus multi-cycle corner sequences.
module tb_gesture_uart_rx;

  localparam int CPB = 10;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] gesture;
  logic       gesture_valid;
  logic       frame_err;
  logic       pkt_err;

  int total = 0;
  int bad   = 0;
  int n_gv  = 0;
  int n_fe  = 0;
  int n_pe  = 0;
  int n_ovl = 0;

  typedef struct {
    logic [39:0] bytes;
    int          n;
    logic [7:0]  g;
    int          gv;
    int          pe;
  } vec_t;

  vec_t vecs[7];

  gesture_uart_rx #(
    .CLK_HZ      (1_000_000),
    .BAUD        (100_000),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .gesture      (gesture),
    .gesture_valid(gesture_valid),
    .frame_err    (frame_err),
    .pkt_err      (pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_gv = n_gv + int'(gesture_valid);
    n_fe = n_fe + int'(frame_err);
    n_pe = n_pe + int'(pkt_err);
    if (int'(gesture_valid) + int'(frame_err) + int'(pkt_err) > 1)
      n_ovl = n_ovl + 1;
  end

  task automatic check(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act,
                           input int lo, input int hi);
    total = total + 1;
    if (act < lo || act > hi) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
  endtask

  task automatic apply(input int idx);
    int pgv;
    int ppe;
    int pfe;
    vec_t v;
    v   = vecs[idx];
    pgv = n_gv;
    ppe = n_pe;
    pfe = n_fe;
    for (int k = 0; k < v.n; k++) send_byte(v.bytes[8*k +: 8], 1'b1);
    idle(20);
    check($sformatf("v%0d_gesture", idx), int'(gesture), int'(v.g));
    check($sformatf("v%0d_gv", idx), n_gv - pgv, v.gv);
    check($sformatf("v%0d_pe", idx), n_pe - ppe, v.pe);
    check($sformatf("v%0d_fe", idx), n_fe - pfe, 0);
  endtask

  initial begin
    int pgv;
    int ppe;
    int pfe;
    int first;

    vecs[0] = '{40'h00_00_FC_03_A5, 3, 8'h03, 1, 0};
    vecs[1] = '{40'h00_00_F4_0B_A5, 3, 8'h0B, 1, 0};
    vecs[2] = '{40'h00_00_00_05_A5, 3, 8'h0B, 0, 1};
    vecs[3] = '{40'hF8_07_A5_05_A5, 5, 8'h07, 1, 1};
    vecs[4] = '{40'h00_00_FE_01_A5, 3, 8'h01, 1, 0};
    vecs[5] = '{40'h00_00_F6_09_A5, 3, 8'h09, 1, 0};
    vecs[6] = '{40'h00_00_FF_00_A5, 3, 8'h00, 1, 0};

    // reset state
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_gesture", int'(gesture), 0);
    check("rst_gv", int'(gesture_valid), 0);
    check("rst_fe", int'(frame_err), 0);
    check("rst_pe", int'(pkt_err), 0);
    reset = 1'b1;
    idle(50);
    check("idle_gesture", int'(gesture), 0);
    check("idle_gv", n_gv, 0);
    check("idle_fe", n_fe, 0);
    check("idle_pe", n_pe, 0);

    // valid packets, bad checksum, resync on SYNC in checksum slot
    for (int i = 0; i < 4; i++) apply(i);

    // bad stop bit followed by a stuck-low line
    pgv = n_gv;
    ppe = n_pe;
    pfe = n_fe;
    send_byte(8'hA5, 1'b0);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    idle(30);
    check("brk_fe", n_fe - pfe, 1);
    check("brk_gv", n_gv - pgv, 0);
    check("brk_pe", n_pe - ppe, 0);
    apply(4);

    // short start glitch is rejected silently
    pgv = n_gv;
    ppe = n_pe;
    pfe = n_fe;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check("glitch_fe", n_fe - pfe, 0);
    check("glitch_pe", n_pe - ppe, 0);
    check("glitch_gv", n_gv - pgv, 0);

    // intra-packet timeout after a lone SYNC
    ppe = n_pe;
    send_byte(8'hA5, 1'b1);
    rx = 1'b1;
    first = -1;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      if (pkt_err && first < 0) first = i;
    end
    check("tmo_count", n_pe - ppe, 1);
    check_rng("tmo_at", first, 192, 204);
    apply(5);

    // reset in the middle of the checksum byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(i[0] ? 1'b0 : 1'b1);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_gesture", int'(gesture), 0);
    pgv = n_gv;
    reset = 1'b1;
    idle(50);
    check("midrst_after_g", int'(gesture), 0);
    check("midrst_after_gv", n_gv - pgv, 0);
    apply(6);

    check("pulse_overlap", n_ovl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
